// File: rtl/wb_pkg.sv
// Shared constants and FSM state type for the writeback stage.
package wb_pkg;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_LOAD = 2'b01;
    localparam logic [1:0] WB_PC4  = 2'b10;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FORMAT = 2'd1,
        WRITE  = 2'd2
    } wb_state_e;

endpackage

// File: rtl/wb_stage_load_align.sv
// Little-endian load extraction and extension; flags misaligned or unknown load sizes.
module load_align
    import wb_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  a,
    input  logic [31:0] mem_word,
    output logic [31:0] data,
    output logic        fault
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = mem_word[7:0];
        case (a)
            2'd1:    byte_v = mem_word[15:8];
            2'd2:    byte_v = mem_word[23:16];
            2'd3:    byte_v = mem_word[31:24];
            default: byte_v = mem_word[7:0];
        endcase
        half_v = a[1] ? mem_word[31:16] : mem_word[15:0];
    end

    always_comb begin
        data  = '0;
        fault = 1'b0;
        case (funct3)
            F3_LB:  data = {{24{byte_v[7]}}, byte_v};
            F3_LBU: data = {24'd0, byte_v};
            F3_LH: begin
                data  = {{16{half_v[15]}}, half_v};
                fault = a[0];
            end
            F3_LHU: begin
                data  = {16'd0, half_v};
                fault = a[0];
            end
            F3_LW: begin
                data  = mem_word;
                fault = (a != 2'd0);
            end
            default: fault = 1'b1;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: latches one instruction, formats its result and holds the
// register-file write stable for HOLD_CYCLES cycles.
//
//  state  | meaning
//  IDLE   | ready for a new instruction
//  FORMAT | result computed from latched inputs and registered
//  WRITE  | write outputs held while the hold counter runs down
module wb_stage
    import wb_pkg::*;
#(
    parameter int HOLD_CYCLES = 10
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_rd,
    input  logic        in_regWrite,
    input  logic [1:0]  in_wbSel,
    input  logic [31:0] in_aluResult,
    input  logic [31:0] in_memData,
    input  logic [31:0] in_pcPlus4,
    input  logic [2:0]  in_funct3,
    output logic        regWrite,
    output logic [4:0]  writeReg,
    output logic [31:0] writeData,
    output logic        retire,
    output logic        loadFault
);

    localparam int CW = $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);

    wb_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]  rd_q, rd_d;
    logic        rw_q, rw_d;
    logic [1:0]  sel_q, sel_d;
    logic [31:0] alu_q, alu_d;
    logic [31:0] mem_q, mem_d;
    logic [31:0] pc4_q, pc4_d;
    logic [2:0]  f3_q, f3_d;
    logic        we_out_q, we_out_d;
    logic [4:0]  reg_out_q, reg_out_d;
    logic [31:0] data_out_q, data_out_d;

    logic [31:0] load_data;
    logic        align_fault;
    logic        fault;
    logic        write_en;
    logic [31:0] result;

    load_align u_load_align (
        .funct3   (f3_q),
        .a        (alu_q[1:0]),
        .mem_word (mem_q),
        .data     (load_data),
        .fault    (align_fault)
    );

    // funct3 only matters for loads, so a non-load can never fault.
    always_comb begin
        fault    = (sel_q == WB_LOAD) && align_fault;
        write_en = rw_q && (rd_q != 5'd0) && !fault;
        case (sel_q)
            WB_LOAD: result = load_data;
            WB_PC4:  result = pc4_q;
            default: result = alu_q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rd_d       = rd_q;
        rw_d       = rw_q;
        sel_d      = sel_q;
        alu_d      = alu_q;
        mem_d      = mem_q;
        pc4_d      = pc4_q;
        f3_d       = f3_q;
        we_out_d   = we_out_q;
        reg_out_d  = reg_out_q;
        data_out_d = data_out_q;
        in_ready   = 1'b0;
        retire     = 1'b0;
        loadFault  = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    rd_d    = in_rd;
                    rw_d    = in_regWrite;
                    sel_d   = in_wbSel;
                    alu_d   = in_aluResult;
                    mem_d   = in_memData;
                    pc4_d   = in_pcPlus4;
                    f3_d    = in_funct3;
                    state_d = FORMAT;
                end
            end
            FORMAT: begin
                if (write_en) begin
                    state_d    = WRITE;
                    cnt_d      = HOLD_LOAD;
                    we_out_d   = 1'b1;
                    reg_out_d  = rd_q;
                    data_out_d = result;
                end else begin
                    state_d   = IDLE;
                    retire    = 1'b1;
                    loadFault = fault;
                end
            end
            WRITE: begin
                if (cnt_q == '0) begin
                    retire     = 1'b1;
                    state_d    = IDLE;
                    we_out_d   = 1'b0;
                    reg_out_d  = '0;
                    data_out_d = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rd_q       <= '0;
            rw_q       <= 1'b0;
            sel_q      <= '0;
            alu_q      <= '0;
            mem_q      <= '0;
            pc4_q      <= '0;
            f3_q       <= '0;
            we_out_q   <= 1'b0;
            reg_out_q  <= '0;
            data_out_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_q       <= rd_d;
            rw_q       <= rw_d;
            sel_q      <= sel_d;
            alu_q      <= alu_d;
            mem_q      <= mem_d;
            pc4_q      <= pc4_d;
            f3_q       <= f3_d;
            we_out_q   <= we_out_d;
            reg_out_q  <= reg_out_d;
            data_out_q <= data_out_d;
        end
    end

    assign regWrite  = we_out_q;
    assign writeReg  = reg_out_q;
    assign writeData = data_out_q;

endmodule

// File: tb/tb_wb_stage.sv
// Randomized and directed bench for wb_stage against a behavioural writeback model.
module tb_wb_stage;

    localparam int H = 10;

    typedef struct {
        logic [4:0]  rd;
        logic        rw;
        logic [1:0]  sel;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [31:0] pc4;
        logic [2:0]  f3;
    } txn_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic        in_regWrite;
    logic [1:0]  in_wbSel;
    logic [31:0] in_aluResult;
    logic [31:0] in_memData;
    logic [31:0] in_pcPlus4;
    logic [2:0]  in_funct3;
    logic        regWrite;
    logic [4:0]  writeReg;
    logic [31:0] writeData;
    logic        retire;
    logic        loadFault;

    int checks = 0;
    int errors = 0;

    wb_stage #(.HOLD_CYCLES(H)) dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_rd        (in_rd),
        .in_regWrite  (in_regWrite),
        .in_wbSel     (in_wbSel),
        .in_aluResult (in_aluResult),
        .in_memData   (in_memData),
        .in_pcPlus4   (in_pcPlus4),
        .in_funct3    (in_funct3),
        .regWrite     (regWrite),
        .writeReg     (writeReg),
        .writeData    (writeData),
        .retire       (retire),
        .loadFault    (loadFault)
    );

    always #5 clock = ~clock;

    // Reference: what the instruction should write, computed arithmetically.
    function automatic void model(input txn_t t, output bit we, output logic [31:0] d, output bit f);
        int unsigned a, b, h;
        f = 0;
        d = t.alu;
        if (t.sel == 2'd2) d = t.pc4;
        else if (t.sel == 2'd1) begin
            a = t.alu % 4;
            b = (t.mem >> (8 * a)) & 32'hFF;
            h = (t.mem >> (16 * (a / 2))) & 32'hFFFF;
            case (t.f3)
                3'd0: d = (b >= 128) ? b + 32'hFFFF_FF00 : b;
                3'd4: d = b;
                3'd1: begin d = (h >= 32768) ? h + 32'hFFFF_0000 : h; f = (a % 2) != 0; end
                3'd5: begin d = h; f = (a % 2) != 0; end
                3'd2: begin d = t.mem; f = (a != 0); end
                default: f = 1;
            endcase
        end
        we = t.rw && (t.rd != 0) && !f;
    endfunction

    function automatic txn_t mk(input logic [4:0] rd, input logic rw, input logic [1:0] sel,
                                input logic [31:0] alu, input logic [31:0] mem, input logic [2:0] f3);
        txn_t t;
        t.rd = rd; t.rw = rw; t.sel = sel; t.alu = alu; t.mem = mem;
        t.pc4 = 32'h0000_4004; t.f3 = f3;
        return t;
    endfunction

    task automatic drive(input txn_t t);
        in_rd        = t.rd;
        in_regWrite  = t.rw;
        in_wbSel     = t.sel;
        in_aluResult = t.alu;
        in_memData   = t.mem;
        in_pcPlus4   = t.pc4;
        in_funct3    = t.f3;
    endtask

    // Presents t and returns just after the rising edge that transfers it.
    task automatic start_txn(input txn_t t, input string nm);
        int n;
        @(negedge clock);
        drive(t);
        in_valid = 1'b1;
        for (n = 0; n < 50 && in_ready !== 1'b1; n++) @(negedge clock);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s accept_timeout: in_ready=%b required 1", nm, in_ready);
        end
        @(posedge clock);
    endtask

    // Observes cycles T+1.. of a transfer at edge T and checks them against the model.
    task automatic observe(input txn_t t, input string nm, input bit have_next, input txn_t nxt,
                           output logic [31:0] seen_data);
        bit ew, ef;
        logic [31:0] ed;
        int rw_cnt, rw_first, ret_cnt, ret_at, flt_cnt, flt_at, last_busy, last_j;
        bit bad_val, ready_bad;
        model(t, ew, ed, ef);
        rw_cnt = 0; rw_first = -1; ret_cnt = 0; ret_at = -1; flt_cnt = 0; flt_at = -1;
        bad_val = 0; ready_bad = 0; seen_data = '0;
        last_busy = ew ? H + 1 : 1;
        last_j = have_next ? last_busy + 1 : H + 2;
        for (int j = 1; j <= last_j; j++) begin
            @(negedge clock);
            if (regWrite === 1'b1) begin
                rw_cnt++;
                if (rw_first < 0) rw_first = j;
                seen_data = writeData;
                if (writeReg !== t.rd || writeData !== ed) bad_val = 1;
            end else if (regWrite !== 1'b0) bad_val = 1;
            if (retire === 1'b1) begin ret_cnt++; ret_at = j; end
            if (loadFault === 1'b1) begin flt_cnt++; flt_at = j; end
            if (j <= last_busy && in_ready !== 1'b0) ready_bad = 1;
            if (j == last_busy + 1) begin
                if (in_ready !== 1'b1) ready_bad = 1;
                if (writeReg !== 5'd0 || writeData !== 32'd0) bad_val = 1;
            end
            if (j == 1 && !have_next) in_valid = 1'b0;
            if (have_next && retire === 1'b1) drive(nxt);
        end
        checks++;
        if (rw_cnt != (ew ? H : 0)) begin
            errors++; $display("FAIL %s regWrite_cycles: got %0d required %0d", nm, rw_cnt, ew ? H : 0);
        end
        checks++;
        if (rw_first != (ew ? 2 : -1)) begin
            errors++; $display("FAIL %s regWrite_start: got %0d required %0d", nm, rw_first, ew ? 2 : -1);
        end
        checks++;
        if (ret_cnt != 1 || ret_at != last_busy) begin
            errors++; $display("FAIL %s retire: count %0d at %0d required 1 at %0d", nm, ret_cnt, ret_at, last_busy);
        end
        checks++;
        if (flt_cnt != (ef ? 1 : 0) || flt_at != (ef ? 1 : -1)) begin
            errors++; $display("FAIL %s loadFault: count %0d at %0d required fault=%0d at 1", nm, flt_cnt, flt_at, ef);
        end
        checks++;
        if (bad_val) begin
            errors++; $display("FAIL %s write_values: last data %h required reg %0d data %h then zero", nm, seen_data, t.rd, ed);
        end
        checks++;
        if (ready_bad) begin
            errors++; $display("FAIL %s in_ready: busy through cycle %0d then 1 not observed", nm, last_busy);
        end
    endtask

    task automatic run(input txn_t t, input string nm, output logic [31:0] seen);
        txn_t dummy;
        dummy = t;
        start_txn(t, nm);
        observe(t, nm, 1'b0, dummy, seen);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        checks++;
        if (in_ready !== 1'b1 || regWrite !== 1'b0 || writeReg !== 5'd0 || writeData !== 32'd0 ||
            retire !== 1'b0 || loadFault !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: ready=%b we=%b reg=%0d data=%h ret=%b flt=%b required 1 0 0 0 0 0",
                     in_ready, regWrite, writeReg, writeData, retire, loadFault);
        end
        reset = 1'b0;
    endtask

    task automatic test_alu;
        logic [31:0] s;
        run(mk(5'd5, 1'b1, 2'b00, 32'h0000_1234, 32'hDEAD_BEEF, 3'd7), "alu", s);
        checks++;
        if (s !== 32'h0000_1234) begin errors++; $display("FAIL alu_data: got %h required 00001234", s); end
        run(mk(5'd3, 1'b1, 2'b11, 32'h0BAD_F00D, 32'h0, 3'd3), "reserved_sel", s);
        checks++;
        if (s !== 32'h0BAD_F00D) begin errors++; $display("FAIL reserved_sel_data: got %h required 0badf00d", s); end
    endtask

    task automatic test_load_ext;
        logic [31:0] s;
        run(mk(5'd1, 1'b1, 2'b01, 32'h0000_1003, 32'h80FF_7F01, 3'd0), "lb", s);
        checks++;
        if (s !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_data: got %h required ffffff80", s); end
        run(mk(5'd2, 1'b1, 2'b01, 32'h0000_1003, 32'h80FF_7F01, 3'd4), "lbu", s);
        checks++;
        if (s !== 32'h0000_0080) begin errors++; $display("FAIL lbu_data: got %h required 00000080", s); end
        run(mk(5'd4, 1'b1, 2'b01, 32'h0000_1002, 32'h80FF_7F01, 3'd1), "lh", s);
        checks++;
        if (s !== 32'hFFFF_80FF) begin errors++; $display("FAIL lh_data: got %h required ffff80ff", s); end
    endtask

    task automatic test_faults;
        logic [31:0] s;
        run(mk(5'd6, 1'b1, 2'b01, 32'h0000_2002, 32'h1234_5678, 3'd2), "lw_misaligned", s);
        run(mk(5'd6, 1'b1, 2'b01, 32'h0000_2001, 32'h1234_5678, 3'd5), "lhu_misaligned", s);
        run(mk(5'd6, 1'b1, 2'b01, 32'h0000_2000, 32'h1234_5678, 3'd3), "illegal_f3", s);
    endtask

    task automatic test_no_write;
        logic [31:0] s;
        run(mk(5'd0, 1'b1, 2'b00, 32'h0000_0055, 32'h0, 3'd0), "rd_zero", s);
        run(mk(5'd9, 1'b0, 2'b10, 32'h0000_0055, 32'h0, 3'd0), "no_regwrite", s);
    endtask

    task automatic test_back_to_back;
        txn_t a, b;
        logic [31:0] s;
        a = mk(5'd7, 1'b1, 2'b00, 32'hCAFE_0001, 32'h0, 3'd0);
        b = mk(5'd9, 1'b1, 2'b10, 32'h0, 32'h0, 3'd0);
        b.pc4 = 32'h0000_8888;
        start_txn(a, "b2b_first");
        observe(a, "b2b_first", 1'b1, b, s);
        @(posedge clock);
        observe(b, "b2b_second", 1'b0, a, s);
        checks++;
        if (s !== 32'h0000_8888) begin errors++; $display("FAIL b2b_second_data: got %h required 00008888", s); end
    endtask

    task automatic test_reset_mid;
        txn_t t;
        logic [31:0] s;
        int rets;
        rets = 0;
        t = mk(5'd12, 1'b1, 2'b00, 32'h0000_00AA, 32'h0, 3'd0);
        start_txn(t, "reset_mid");
        for (int j = 1; j <= 5; j++) begin
            @(negedge clock);
            if (j == 1) in_valid = 1'b0;
            if (retire === 1'b1) rets++;
        end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || regWrite !== 1'b0 || writeReg !== 5'd0 || writeData !== 32'd0 ||
            retire !== 1'b0 || loadFault !== 1'b0 || rets != 0) begin
            errors++;
            $display("FAIL reset_mid_outputs: ready=%b we=%b reg=%0d data=%h ret=%b flt=%b early_retires=%0d required 1 0 0 0 0 0 0",
                     in_ready, regWrite, writeReg, writeData, retire, loadFault, rets);
        end
        run(mk(5'd13, 1'b1, 2'b00, 32'h0000_0BBB, 32'h0, 3'd0), "after_reset", s);
    endtask

    task automatic test_random;
        txn_t t;
        logic [31:0] s;
        for (int i = 0; i < 24; i++) begin
            t.rd  = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 5) == 0) t.rd = 5'd0;
            t.rw  = ($urandom_range(0, 7) != 0);
            t.sel = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b01;
            t.alu = $urandom;
            t.mem = $urandom;
            t.pc4 = $urandom;
            t.f3  = 3'($urandom_range(0, 7));
            run(t, $sformatf("random_%0d", i), s);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        drive(mk(5'd0, 1'b0, 2'b00, 32'h0, 32'h0, 3'd0));
        test_reset;
        test_alu;
        test_load_ext;
        test_faults;
        test_no_write;
        test_back_to_back;
        test_reset_mid;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the multi-cycle datapath, sitting directly upstream of the register file. It accepts one completed instruction per transaction, selects and formats the result (ALU, aligned and extended load data, or PC+4), and drives `regWrite`/`writeReg`/`writeData` into the register file. It holds those values stable long enough to cover the register file's internal write phase. It also flags misaligned or illegal loads and emits a one-cycle retire pulse per instruction.

## Interface
- `HOLD_CYCLES`, 10: cycles that `regWrite`/`writeReg`/`writeData` stay asserted and stable. It must be at least the register file's phase period.
- `clock` input 1: single clock, all state updates on the rising edge.
- `reset` input 1: reset is synchronous and active-high.
- `in_valid` input 1: upstream transaction present.
- `in_ready` output 1: stage can accept. A transfer occurs when `in_valid` and `in_ready` are both high on a rising edge.
- `in_rd` input 5: destination register.
- `in_regWrite` input 1: instruction writes a register.
- `in_wbSel` input 2: result source. 00 = ALU, 01 = load, 10 = PC+4, 11 = reserved and treated as ALU.
- `in_aluResult` input 32: ALU result; bits [1:0] are the load address low bits.
- `in_memData` input 32: raw word read from data memory.
- `in_pcPlus4` input 32: link value.
- `in_funct3` input 3: load size/sign code.
- `regWrite` output 1: write enable to the register file.
- `writeReg` output 5: write address to the register file.
- `writeData` output 32: write data to the register file.
- `retire` output 1: one-cycle pulse per completed transaction.
- `loadFault` output 1: one-cycle pulse when a load is misaligned or has an illegal `in_funct3`; that load performs no write.

## Operation
- FSM states:
  - IDLE: `in_ready`=1. On a transfer, latch all inputs and go to FORMAT.
  - FORMAT: compute the result and register it. Go to WRITE if the write is enabled, otherwise return to IDLE with `retire`=1.
  - WRITE: drive the outputs and count down `HOLD_CYCLES`. On the final cycle assert `retire` and return to IDLE.
- The write is enabled only when `in_regWrite`=1, `in_rd`≠0, and there is no load fault.
- Load formatting is little-endian. `a` = `in_aluResult[1:0]`; `byte` = `in_memData[8a+7:8a]`; `half` = `in_memData[16·a[1]+15 : 16·a[1]]`.
  - funct3 000 = LB: sign-extend `byte`.
  - 100 = LBU: zero-extend `byte`.
  - 001 = LH: sign-extend `half`; fault if a[0]=1.
  - 101 = LHU: zero-extend `half`; fault if a[0]=1.
  - 010 = LW: full word; fault if a≠0.
  - Any other funct3 faults.
- `in_funct3` is ignored when `in_wbSel`≠01.
- The hold counter is `$clog2(HOLD_CYCLES+1)` bits wide. It loads `HOLD_CYCLES`−1 on entry to WRITE and leaves WRITE when it reaches 0.

## Timing
- Reset values: `in_ready`=1, `regWrite`=0, `writeReg`=0, `writeData`=0, `retire`=0, `loadFault`=0. FSM returns to IDLE.
- Reset mid-transaction drops the transaction with no retire and no fault.
- Transfer at edge T: FORMAT occupies cycle T+1. `regWrite` is high from T+2 through T+1+`HOLD_CYCLES` inclusive. `retire` is high in the last of those cycles.
- `writeReg` and `writeData` are constant for the whole time `regWrite` is high. All three return to 0 the cycle after WRITE ends.
- Skipped write: `retire` (and `loadFault`, if applicable) pulse in cycle T+1, and `in_ready`=1 again at T+2.
- `in_ready` is 0 in FORMAT and WRITE. Upstream `in_valid` in those states is ignored and must be held until accepted.
- Back-to-back operation: a new transfer can occur in the cycle immediately after `retire`. Steady-state period is `HOLD_CYCLES`+2 cycles.

## Structure
- Package `wb_pkg` holds:
  - `wbSel` constants: WB_ALU, WB_LOAD, WB_PC4.
  - Load funct3 constants: F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU.
  - FSM state enum: IDLE, FORMAT, WRITE.
- Sub-module `load_align` is purely combinational: inputs funct3, a, mem word; outputs data and fault. It is instantiated once in `wb_stage`.

## Test plan
- ALU writeback: rd=5, wbSel=00, alu=0x0000_1234, HOLD=10. Required: `regWrite` high for exactly 10 cycles starting 2 after the transfer, with `writeReg`=5 and `writeData`=0x1234. `retire` is asserted on the 10th cycle.
- LB sign/zero extension: mem=0x80FF_7F01, a=3. LB writes 0xFFFF_FF80; LBU writes 0x0000_0080. LH with a=2 writes 0xFFFF_80FF.
- Misaligned LW: a=2. Required: `loadFault` and `retire` pulse together 1 cycle after the transfer, `regWrite` never rises, and `in_ready` is 1 two cycles after the transfer.
- rd=0 with `in_regWrite`=1, or `in_regWrite`=0: no `regWrite`, and `retire` pulses at T+1.
- Back-to-back: `in_valid` held high with two transactions queued. Required: the second transfer happens the cycle after the first `retire`, and `in_ready` stays 0 throughout the first transaction.
- Reset asserted in WRITE cycle 4: next cycle all outputs are 0 and `in_ready`=1, with no `retire`. A following transaction completes normally.
